instr_stream_player: RTL and testbench

//  CPU-loaded program memory that plays a 16-bit instruction stream to the experiment FSM's instruction port.
//  It drives tvalid/tdata and accepts tready, and signals end-of-program on halt.
//  The CPU loads words through a simple write port, sets the length and loop count, then pulses start.
//  The block replays the program (loop_count+1) times at up to one word per clock.

---
 rtl/instr_stream_player.sv | 199 +++++++++++++++++++
 tb/tb_instr_stream_player.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_stream_player.sv
// CPU-loaded program memory that replays a 16-bit instruction stream over AXI-Stream.
// Optional handshake counter on words_sent is built when INSTR_PLAYER_COUNT_EN is defined.
module instr_stream_player #(
    parameter int unsigned PROG_DEPTH = 1024,
    parameter int unsigned AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_wr_en,
    input  logic [AW-1:0] prog_wr_addr,
    input  logic [15:0]   prog_wr_data,
    input  logic [AW:0]   prog_len,
    input  logic [15:0]   loop_count,
    input  logic          start,
    output logic [15:0]   m_axis_tdata,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tready,
    output logic          halt,
    output logic          busy,
    output logic          wr_err,
    output logic [31:0]   words_sent
);

    typedef enum logic [1:0] {StIdle, StPrefetch, StStream, StHalt} state_e;

    localparam logic [AW:0] DepthW = (AW+1)'(PROG_DEPTH);

    state_e        state_q, state_d;
    logic [15:0]   mem [PROG_DEPTH];
    logic [15:0]   rd_data_q;
    logic          rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic [AW:0]   len_q, len_d;
    logic [15:0]   loops_q, loops_d;
    logic          fetch_done_q, fetch_done_d;
    logic          out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [15:0]   out_data_q, out_data_d;
    logic          skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
    logic [15:0]   skid_data_q, skid_data_d;
    logic          wr_err_q, wr_err_d;

    logic [AW:0]   len_sat;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   cur_len;
    logic [15:0]   cur_loops;
    logic          at_end, issue, pop;
    logic [1:0]    occ_next;

    assign len_sat = (prog_len > DepthW) ? DepthW : prog_len;
    assign pop     = out_valid_q && m_axis_tready;
    // Entries held after this edge; a read may be issued only if its word is sure to fit.
    assign occ_next = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, rd_valid_q}
                    - {1'b0, pop};

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        loops_d      = loops_q;
        fetch_addr_d = fetch_addr_q;
        fetch_done_d = fetch_done_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        wr_err_d     = wr_err_q | (prog_wr_en && (state_q != StIdle));
        issue        = 1'b0;

        // In IDLE the fetch pointer comes straight from the CPU-side inputs.
        cur_addr  = fetch_addr_q;
        cur_len   = len_q;
        cur_loops = loops_q;
        if (state_q == StIdle) begin
            cur_addr  = '0;
            cur_len   = len_sat;
            cur_loops = loop_count;
        end
        at_end = ({1'b0, cur_addr} == (cur_len - (AW+1)'(1)));

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d        = len_sat;
                    loops_d      = loop_count;
                    fetch_done_d = 1'b0;
                    if (len_sat == '0) begin
                        state_d = StHalt;
                    end else begin
                        issue   = 1'b1;
                        state_d = StPrefetch;
                    end
                end
            end
            StPrefetch: begin
                issue   = !fetch_done_q && (occ_next <= 2'd1);
                state_d = StStream;
            end
            StStream: begin
                issue = !fetch_done_q && (occ_next <= 2'd1);
                if (pop && out_last_q) state_d = StHalt;
            end
            StHalt: begin
                if (!start) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        rd_valid_d = issue;
        rd_last_d  = issue && at_end && (cur_loops == '0);
        if (issue) begin
            if (at_end) begin
                fetch_addr_d = '0;
                if (cur_loops == '0) fetch_done_d = 1'b1;
                else                 loops_d      = cur_loops - 16'd1;
            end else begin
                fetch_addr_d = cur_addr + AW'(1);
            end
        end

        // Output register is head, skid is second, arriving memory word joins the tail.
        if (out_valid_q && !pop) begin
            if (!skid_valid_q && rd_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = rd_data_q;
                skid_last_d  = rd_last_q;
            end
        end else if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            out_last_d   = skid_last_q;
            skid_valid_d = rd_valid_q;
            skid_data_d  = rd_data_q;
            skid_last_d  = rd_last_q;
        end else begin
            out_valid_d = rd_valid_q;
            out_last_d  = rd_valid_q && rd_last_q;
            if (rd_valid_q) out_data_d = rd_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (prog_wr_en && (state_q == StIdle)) mem[prog_wr_addr] <= prog_wr_data;
        if (issue) rd_data_q <= mem[cur_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            fetch_addr_q <= '0;
            len_q        <= '0;
            loops_q      <= '0;
            fetch_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
            fetch_addr_q <= fetch_addr_d;
            len_q        <= len_d;
            loops_q      <= loops_d;
            fetch_done_q <= fetch_done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            wr_err_q     <= wr_err_d;
        end
    end

`ifdef INSTR_PLAYER_COUNT_EN
    logic [31:0] words_q;
    always_ff @(posedge clk) begin
        if (!rst)                            words_q <= '0;
        else if ((state_q == StIdle) && start) words_q <= '0;
        else if (out_valid_q && m_axis_tready) words_q <= words_q + 32'd1;
    end
    assign words_sent = words_q;
`else
    assign words_sent = '0;
`endif

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign halt          = (state_q == StHalt);
    assign busy          = (state_q != StIdle);
    assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_instr_stream_player.sv
// Randomized bench for instr_stream_player against a queue-based playback model.
module tb_instr_stream_player;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_wr_en = 1'b0;
    logic [AW-1:0] prog_wr_addr = '0;
    logic [15:0]   prog_wr_data = '0;
    logic [AW:0]   prog_len = '0;
    logic [15:0]   loop_count = '0;
    logic          start = 1'b0;
    logic [15:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          halt, busy, wr_err;
    logic [31:0]   words_sent;

    logic [15:0] model_mem [DEPTH];
    int vectors = 0;
    int errors  = 0;

    instr_stream_player #(.PROG_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .prog_wr_en    (prog_wr_en),
        .prog_wr_addr  (prog_wr_addr),
        .prog_wr_data  (prog_wr_data),
        .prog_len      (prog_len),
        .loop_count    (loop_count),
        .start         (start),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .halt          (halt),
        .busy          (busy),
        .wr_err        (wr_err),
        .words_sent    (words_sent)
    );

    always #5 clk = ~clk;

    function automatic int exp_count(input int n);
`ifdef INSTR_PLAYER_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic load_word(input int addr, input logic [15:0] data);
        prog_wr_en   = 1'b1;
        prog_wr_addr = AW'(addr);
        prog_wr_data = data;
        @(negedge clk);
        prog_wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    // One complete run; mode 0: tready high, 1: toggling, 2: random.
    task automatic play(input int len, input int loops, input int mode,
                        input bit busy_write, input bit check_timing);
        int exp_q[$];
        int eff_len, total, cyc, hs, budget;
        bit prev_stall, seen_valid;
        logic [15:0] prev_data, want;
        eff_len = (len > DEPTH) ? DEPTH : len;
        for (int p = 0; p <= loops; p++)
            for (int i = 0; i < eff_len; i++) exp_q.push_back(int'(model_mem[i]));
        total = exp_q.size();
        budget = total * 3 + 20;
        prog_len = (AW+1)'(len);
        loop_count = 16'(loops);
        start = 1'b1;
        cyc = 0; hs = 0; prev_stall = 0; seen_valid = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > budget) begin
                $display("FAIL run_timeout: %0d of %0d words seen, no halt", hs, total);
                errors++; vectors++;
                break;
            end
            vectors++;
            if (m_axis_tvalid && halt) begin
                $display("FAIL halt_with_valid: cycle %0d tvalid=1 halt=1, need halt=0", cyc);
                errors++;
            end
            if (prev_stall) begin
                vectors++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data) begin
                    $display("FAIL stall_hold: tvalid=%b tdata=%h, need 1 %h",
                             m_axis_tvalid, m_axis_tdata, prev_data);
                    errors++;
                end
            end
            if (seen_valid && !m_axis_tvalid && !halt) begin
                $display("FAIL valid_drop: tvalid fell at cycle %0d before final word", cyc);
                errors++; vectors++;
            end
            if (check_timing && cyc <= 2) begin
                vectors++;
                if (m_axis_tvalid !== (cyc == 2)) begin
                    $display("FAIL first_valid: cycle %0d tvalid=%b, need %b",
                             cyc, m_axis_tvalid, cyc == 2);
                    errors++;
                end
            end
            if (halt) begin
                vectors++;
                if (exp_q.size() != 0 || hs != total) begin
                    $display("FAIL early_halt: halted after %0d words, need %0d", hs, total);
                    errors++;
                end
                if (check_timing && mode == 0) begin
                    vectors++;
                    if (cyc != total + 2) begin
                        $display("FAIL halt_cycle: halt at cycle %0d, need %0d", cyc, total + 2);
                        errors++;
                    end
                end
                vectors++;
                if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin
                    $display("FAIL halt_state: busy=%b tvalid=%b, need 1 0", busy, m_axis_tvalid);
                    errors++;
                end
                vectors++;
                if (words_sent !== 32'(exp_count(total))) begin
                    $display("FAIL words_sent: got %0d, need %0d", words_sent, exp_count(total));
                    errors++;
                end
                break;
            end
            prog_wr_en = busy_write && (cyc == 3);
            prog_wr_addr = '0;
            prog_wr_data = 16'hBEEF;
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = cyc[0];
                default: m_axis_tready = 1'($urandom_range(1));
            endcase
            if (m_axis_tvalid) seen_valid = 1;
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    $display("FAIL extra_word: tdata=%h beyond %0d words", m_axis_tdata, total);
                    errors++;
                end else begin
                    want = 16'(exp_q.pop_front());
                    if (m_axis_tdata !== want) begin
                        $display("FAIL word_%0d: tdata=%h, need %h", hs, m_axis_tdata, want);
                        errors++;
                    end
                end
                hs++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
        end
        prog_wr_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (halt !== 1'b0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            $display("FAIL idle_return: halt=%b busy=%b tvalid=%b, need 0 0 0",
                     halt, busy, m_axis_tvalid);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 16'h0 || halt !== 1'b0 ||
            busy !== 1'b0 || wr_err !== 1'b0 || words_sent !== 32'h0) begin
            $display("FAIL reset_state: tvalid=%b tdata=%h halt=%b busy=%b wr_err=%b ws=%0d, need all 0",
                     m_axis_tvalid, m_axis_tdata, halt, busy, wr_err, words_sent);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pass();
        load_word(0, 16'h0001);
        load_word(1, 16'h0002);
        load_word(2, 16'h0003);
        play(3, 0, 0, 0, 1);
    endtask

    task automatic test_loops_stall();
        play(3, 2, 1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            int n;
            n = int'($urandom_range(8, 1));
            for (int i = 0; i < n; i++) load_word(i, 16'($urandom));
            play(n, int'($urandom_range(3)), 2, 0, 1);
        end
    endtask

    task automatic test_zero_len();
        prog_len = '0;
        loop_count = 16'd5;
        start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            vectors++;
            if (m_axis_tvalid !== 1'b0 || busy !== 1'b1 || (c >= 2 && halt !== 1'b1)) begin
                $display("FAIL zero_len: cycle %0d tvalid=%b busy=%b halt=%b, need 0 1 1",
                         c, m_axis_tvalid, busy, halt);
                errors++;
            end
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || halt !== 1'b0 || words_sent !== 32'h0) begin
            $display("FAIL zero_len_idle: busy=%b halt=%b ws=%0d, need 0 0 0",
                     busy, halt, words_sent);
            errors++;
        end
    endtask

    task automatic test_busy_write();
        load_word(0, 16'h0001);
        play(3, 0, 0, 1, 0);
        vectors++;
        if (wr_err !== 1'b1) begin
            $display("FAIL wr_err_set: wr_err=%b, need 1", wr_err);
            errors++;
        end
        load_word(0, 16'hBEEF);
        play(3, 0, 2, 0, 0);
        vectors++;
        if (wr_err !== 1'b1) begin
            $display("FAIL wr_err_sticky: wr_err=%b, need 1", wr_err);
            errors++;
        end
    endtask

    task automatic test_reset_midrun();
        int hs, c;
        for (int i = 0; i < 5; i++) load_word(i, 16'($urandom));
        prog_len = 11'd5;
        loop_count = '0;
        start = 1'b1;
        m_axis_tready = 1'b1;
        hs = 0; c = 0;
        while (hs < 2 && c < 20) begin
            @(negedge clk);
            c++;
            if (m_axis_tvalid) begin
                vectors++;
                if (m_axis_tdata !== model_mem[hs]) begin
                    $display("FAIL pre_reset_word_%0d: tdata=%h, need %h",
                             hs, m_axis_tdata, model_mem[hs]);
                    errors++;
                end
                hs++;
            end
        end
        vectors++;
        if (hs < 2) begin
            $display("FAIL pre_reset_timeout: %0d words, need 2", hs);
            errors++;
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (m_axis_tvalid !== 1'b0 || halt !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL midrun_reset: tvalid=%b halt=%b busy=%b, need 0 0 0",
                     m_axis_tvalid, halt, busy);
            errors++;
        end
        rst = 1'b1;
        @(negedge clk);
        play(5, 0, 0, 0, 1);
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
        play(DEPTH, 1, 0, 0, 1);
        play(2047, 0, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_loops_stall();
        test_zero_len();
        test_busy_write();
        test_reset_midrun();
        test_full_depth();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
